// File: rtl/sim_run_ctrl.sv
// sim_run_ctrl: run-control sequencer for the simulation top.
// Holds the DUT in reset after bench reset, counts run cycles, gates the log
// window, emits periodic perf dump/clean pulses and drains into a sticky
// finish with a reason code on stop request or cycle timeout.
module sim_run_ctrl #(
  parameter int RESET_CYCLES = 50,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] cfg_log_begin,
  input  logic [63:0] cfg_log_end,
  input  logic [31:0] cfg_max_cycles,
  input  logic [31:0] cfg_perf_interval,
  input  logic        stop_req,
  input  logic        stop_err,
  output logic        dut_reset,
  output logic [63:0] cycle_cnt,
  output logic        log_en,
  output logic        perf_clean,
  output logic        perf_dump,
  output logic        finish,
  output logic [1:0]  finish_code
);

  typedef enum logic [1:0] {HOLD, RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] HOLD_LAST  = 32'(RESET_CYCLES - 1);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

  localparam logic [1:0] CODE_GOOD    = 2'd1;
  localparam logic [1:0] CODE_ERR     = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;

  state_t      state_q, state_d;
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] drain_cnt_q, drain_cnt_d;
  logic [63:0] cnt_q, cnt_d;
  // pcnt counts down to the next periodic dump; 0 means "dump this cycle"
  logic [31:0] pcnt_q, pcnt_d;
  logic [1:0]  code_q, code_d;

  // Configuration captured on the HOLD->RUN edge
  logic [63:0] lb_q, lb_d;
  logic [63:0] le_q, le_d;
  logic [31:0] max_q, max_d;
  logic [31:0] intv_q, intv_d;

  // Registered outputs
  logic        dut_reset_q, dut_reset_d;
  logic        log_en_q, log_en_d;
  logic        perf_dump_q, perf_dump_d;
  logic        perf_clean_q, perf_clean_d;
  logic        finish_q, finish_d;
  logic [1:0]  finish_code_q, finish_code_d;

  logic        per_hit;

  // Next-state, counters and next output values
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    drain_cnt_d  = drain_cnt_q;
    cnt_d        = cnt_q;
    pcnt_d       = pcnt_q;
    code_d       = code_q;
    lb_d         = lb_q;
    le_d         = le_q;
    max_d        = max_q;
    intv_d       = intv_q;
    perf_dump_d  = 1'b0;
    perf_clean_d = 1'b0;
    per_hit      = (intv_q != 32'd0) && (pcnt_q == 32'd0);

    case (state_q)
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d     = RUN;
          hold_cnt_d  = 32'd0;
          lb_d        = cfg_log_begin;
          le_d        = cfg_log_end;
          max_d       = cfg_max_cycles;
          intv_d      = cfg_perf_interval;
          cnt_d       = 64'd0;
          pcnt_d      = cfg_perf_interval - 32'd1;
          perf_dump_d = (cfg_perf_interval == 32'd1);
        end else begin
          hold_cnt_d  = hold_cnt_q + 32'd1;
        end
      end
      RUN: begin
        // the cycle after a periodic dump cleans, even if it lands in DRAIN
        perf_clean_d = per_hit;
        if (stop_req) begin
          state_d = DRAIN;
          code_d  = stop_err ? CODE_ERR : CODE_GOOD;
        end else if ((max_q != 32'd0) && ((cnt_q + 64'd1) == {32'd0, max_q})) begin
          state_d = DRAIN;
          code_d  = CODE_TIMEOUT;
        end
        if (state_d == DRAIN) begin
          // cycle_cnt freezes; first DRAIN cycle carries the final dump
          drain_cnt_d = 32'd0;
          perf_dump_d = 1'b1;
        end else begin
          cnt_d       = cnt_q + 64'd1;
          pcnt_d      = (pcnt_q == 32'd0) ? (intv_q - 32'd1) : (pcnt_q - 32'd1);
          perf_dump_d = (intv_q != 32'd0) && (pcnt_d == 32'd0);
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) state_d = DONE;
        else drain_cnt_d = drain_cnt_q + 32'd1;
      end
      default: ;
    endcase

    dut_reset_d   = (state_d == HOLD);
    log_en_d      = (state_d == RUN) && (cnt_d >= lb_d) && (cnt_d < le_d);
    finish_d      = (state_d == DONE);
    finish_code_d = finish_d ? code_d : 2'd0;
  end

  // State and output registers, synchronous reset back to HOLD
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= HOLD;
      hold_cnt_q    <= 32'd0;
      drain_cnt_q   <= 32'd0;
      cnt_q         <= 64'd0;
      pcnt_q        <= 32'd0;
      code_q        <= 2'd0;
      lb_q          <= 64'd0;
      le_q          <= 64'd0;
      max_q         <= 32'd0;
      intv_q        <= 32'd0;
      dut_reset_q   <= 1'b1;
      log_en_q      <= 1'b0;
      perf_dump_q   <= 1'b0;
      perf_clean_q  <= 1'b0;
      finish_q      <= 1'b0;
      finish_code_q <= 2'd0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      cnt_q         <= cnt_d;
      pcnt_q        <= pcnt_d;
      code_q        <= code_d;
      lb_q          <= lb_d;
      le_q          <= le_d;
      max_q         <= max_d;
      intv_q        <= intv_d;
      dut_reset_q   <= dut_reset_d;
      log_en_q      <= log_en_d;
      perf_dump_q   <= perf_dump_d;
      perf_clean_q  <= perf_clean_d;
      finish_q      <= finish_d;
      finish_code_q <= finish_code_d;
    end
  end

  assign dut_reset   = dut_reset_q;
  assign cycle_cnt   = cnt_q;
  assign log_en      = log_en_q;
  assign perf_dump   = perf_dump_q;
  assign perf_clean  = perf_clean_q;
  assign finish      = finish_q;
  assign finish_code = finish_code_q;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// tb_sim_run_ctrl: directed and randomized scenarios for sim_run_ctrl,
// every cycle compared against a phase-based model of the run sequence.
module tb_sim_run_ctrl;
  localparam int R = 50;
  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] cfg_log_begin, cfg_log_end;
  logic [31:0] cfg_max_cycles, cfg_perf_interval;
  logic        stop_req, stop_err;
  logic        dut_reset, log_en, perf_clean, perf_dump, finish;
  logic [63:0] cycle_cnt;
  logic [1:0]  finish_code;

  int checks   = 0;
  int failures = 0;

  sim_run_ctrl #(.RESET_CYCLES(R), .DRAIN_CYCLES(D)) dut (
    .clock(clock), .reset(reset),
    .cfg_log_begin(cfg_log_begin), .cfg_log_end(cfg_log_end),
    .cfg_max_cycles(cfg_max_cycles), .cfg_perf_interval(cfg_perf_interval),
    .stop_req(stop_req), .stop_err(stop_err),
    .dut_reset(dut_reset), .cycle_cnt(cycle_cnt), .log_en(log_en),
    .perf_clean(perf_clean), .perf_dump(perf_dump),
    .finish(finish), .finish_code(finish_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s k=%0d observed=%0d expected=%0d", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all(input string ph, input int k, input bit e_rst, input logic [63:0] e_cnt,
                         input bit e_log, input bit e_dump, input bit e_clean,
                         input bit e_fin, input logic [1:0] e_code);
    chk({ph, ".dut_reset"},   k, 64'(dut_reset),   64'(e_rst));
    chk({ph, ".cycle_cnt"},   k, cycle_cnt,        e_cnt);
    chk({ph, ".log_en"},      k, 64'(log_en),      64'(e_log));
    chk({ph, ".perf_dump"},   k, 64'(perf_dump),   64'(e_dump));
    chk({ph, ".perf_clean"},  k, 64'(perf_clean),  64'(e_clean));
    chk({ph, ".finish"},      k, 64'(finish),      64'(e_fin));
    chk({ph, ".finish_code"}, k, 64'(finish_code), 64'(e_code));
  endtask

  // One run: bench reset for 3 cycles, then k counts edges with reset low.
  // stop_at < 0 means no stop request; abort_k >= 0 re-asserts reset after cycle k.
  task automatic run_scn(input logic [63:0] lb, input logic [63:0] le,
                         input logic [31:0] mx, input logic [31:0] pi,
                         input longint stop_at, input bit err,
                         input int abort_k, input int hold_stop_k);
    longint      s, run_end, done_k, c, pil;
    logic [1:0]  code;
    logic [63:0] cu;
    bit          e_rst, e_log, e_dump, e_clean, e_fin;
    logic [63:0] e_cnt;
    logic [1:0]  e_code;

    // Reference: last RUN cycle index and reason, from the stop rules
    pil = longint'(pi);
    if (stop_at >= 0 && (mx == 32'd0 || stop_at < longint'(mx))) begin
      s = stop_at; code = err ? 2'd2 : 2'd1;
    end else begin
      s = longint'(mx) - 1; code = 2'd3;
    end
    run_end = R + s + 1;
    done_k  = run_end + D;

    reset = 1'b1; stop_req = 1'b0; stop_err = 1'b0;
    cfg_log_begin = lb; cfg_log_end = le; cfg_max_cycles = mx; cfg_perf_interval = pi;
    repeat (3) begin
      @(negedge clock);
      chk_all("rst", 0, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
    end
    reset = 1'b0;

    for (int k = 1; longint'(k) <= done_k + 3; k++) begin
      @(negedge clock);
      e_rst = 1'b1; e_cnt = 64'd0; e_log = 1'b0; e_dump = 1'b0;
      e_clean = 1'b0; e_fin = 1'b0; e_code = 2'd0;
      if (k >= R && longint'(k) < run_end) begin
        c = longint'(k - R); cu = 64'(c);
        e_rst   = 1'b0; e_cnt = cu;
        e_log   = (cu >= lb) && (cu < le);
        e_dump  = (pil != 0) && ((c + 1) % pil == 0);
        e_clean = (pil != 0) && (c > 0) && (c % pil == 0);
      end else if (longint'(k) >= run_end && longint'(k) < done_k) begin
        e_rst   = 1'b0; e_cnt = 64'(s);
        e_dump  = (longint'(k) == run_end);
        e_clean = (longint'(k) == run_end) && (pil != 0) && ((s + 1) % pil == 0);
      end else if (longint'(k) >= done_k) begin
        e_rst = 1'b0; e_cnt = 64'(s); e_fin = 1'b1; e_code = code;
      end
      chk_all("run", k, e_rst, e_cnt, e_log, e_dump, e_clean, e_fin, e_code);

      if (k == abort_k) begin
        reset = 1'b1; stop_req = 1'b0;
        @(negedge clock);
        chk_all("abort", k + 1, 1'b1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0);
        return;
      end

      // Drive inputs for the next edge
      if (k < R) begin
        stop_req = (k == hold_stop_k);
        stop_err = 1'($urandom_range(0, 1));
      end else if (longint'(k) < run_end) begin
        stop_req = (longint'(k - R) == stop_at);
        stop_err = stop_req ? err : 1'($urandom_range(0, 1));
      end else begin
        stop_req = 1'($urandom_range(0, 1));
        stop_err = 1'($urandom_range(0, 1));
      end
      if (k >= R) begin
        cfg_log_begin     = {$urandom, $urandom};
        cfg_log_end       = {$urandom, $urandom};
        cfg_max_cycles    = $urandom;
        cfg_perf_interval = $urandom;
      end
    end
  endtask

  initial begin
    logic [31:0] mx, pi;
    longint      sa;
    int          ab;

    // Log window 10..19, perf every 8, good stop at 30, stop pulse in HOLD
    run_scn(64'd10, 64'd20, 32'd0, 32'd8, 30, 1'b0, -1, 10);
    // Inverted log window, perf disabled, good stop at 5
    run_scn(64'd20, 64'd10, 32'd0, 32'd0, 5, 1'b0, -1, 3);
    // Timeout at 100 cycles
    run_scn(64'd0, 64'd200, 32'd100, 32'd7, -1, 1'b0, -1, 1);
    // Error stop in the same cycle as timeout wins
    run_scn(64'd0, 64'd200, 32'd100, 32'd10, 99, 1'b1, -1, 49);
    // Single RUN cycle, dump every cycle
    run_scn(64'd0, 64'd1, 32'd1, 32'd1, -1, 1'b0, -1, 20);
    // Reset mid-DRAIN (stop at 12 -> DRAIN starts at k=63)
    run_scn(64'd0, 64'd5, 32'd0, 32'd3, 12, 1'b1, 65, 7);
    // Reset mid-DONE (stop at 5 -> DONE at k=60), then fresh cfg captured
    run_scn(64'd2, 64'd4, 32'd0, 32'd2, 5, 1'b0, 62, 8);
    run_scn(64'd3, 64'd9, 32'd12, 32'd4, -1, 1'b0, -1, 30);

    for (int i = 0; i < 30; i++) begin
      mx = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom_range(1, 150);
      sa = (mx != 32'd0 && $urandom_range(0, 2) == 0) ? -1 : longint'($urandom_range(0, 150));
      pi = $urandom_range(0, 12);
      ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 250)) : -1;
      run_scn(64'($urandom_range(0, 80)), 64'($urandom_range(0, 80)), mx, pi, sa,
              1'($urandom_range(0, 1)), ab, int'($urandom_range(1, R - 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
